// File: rtl/cache_line_serializer.sv
// Write-back transmitter: takes one cache line in parallel and streams it to memory
// as SHIFT_LEN-bit beats, least-significant beat first, each tagged with its byte address.
module cache_line_serializer #(
    parameter int CASH_STR_WIDTH = 64,
    parameter int SHIFT_LEN      = 32,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CASH_STR_WIDTH-1:0] in_line,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SHIFT_LEN-1:0]      out_data,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int BEATS      = CASH_STR_WIDTH / SHIFT_LEN;
    localparam int BEAT_BYTES = SHIFT_LEN / 8;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BEAT_BYTES);

    // Handshake rule on both sides: a transfer happens on the rising edge where
    // valid and ready are both high; valid, once raised, holds with stable payload
    // until that edge.

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CASH_STR_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      accept;
    logic                      beat_fire;
    logic                      last_beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // busy is the externally visible copy of the FSM state (1 = SEND).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        beat_fire = 1'b0;
        last_beat = (beat_cnt == LAST_BEAT);
        case (state)
            IDLE: begin
                in_ready = !reset;
                accept   = in_valid && !reset;
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                beat_fire = out_ready;
                if (out_ready && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are forced to zero outside SEND so an idle bus carries no stale beat.
    always_comb begin
        out_data = '0;
        out_addr = '0;
        out_last = 1'b0;
        if (busy) begin
            out_data = data[SHIFT_LEN-1:0];
            out_addr = addr;
            out_last = last_beat;
        end
    end

    // The address advances alongside the shift, which equals base + beat_cnt*BEAT_BYTES
    // modulo 2^ADDR_WIDTH without needing a multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= '0;
            addr     <= '0;
            beat_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= beat_fire && last_beat;
            if (accept) begin
                data     <= in_line;
                addr     <= in_addr;
                beat_cnt <= '0;
            end else if (beat_fire) begin
                data     <= data >> SHIFT_LEN;
                addr     <= addr + ADDR_STEP;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_serializer.sv
// Bench for cache_line_serializer: vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based model of the beat stream.
module tb_cache_line_serializer;

    localparam int LW    = 64;
    localparam int SL    = 32;
    localparam int AW    = 16;
    localparam int BEATS = LW / SL;
    localparam int BB    = SL / 8;
    localparam int BW    = SL + AW + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_line;
    logic [AW-1:0] in_addr;
    logic          out_valid;
    logic          out_ready;
    logic [SL-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    cache_line_serializer #(
        .CASH_STR_WIDTH(LW),
        .SHIFT_LEN     (SL),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_line  (in_line),
        .in_addr  (in_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_q[$];
    logic          exp_done  = 1'b0;
    logic          exp_done_nxt;
    logic          in_fire_s = 1'b0;
    logic          fire_done = 1'b0;
    logic          rand_mode = 1'b0;
    logic [BW-1:0] head;
    logic [LW-1:0] sh;
    logic [AW-1:0] ba;
    logic          exp_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // Monitor/model on the falling edge: checks what the DUT shows now and predicts
    // what the coming rising edge will transfer.
    initial begin
        forever begin
            @(negedge clk);
            exp_v = (exp_q.size() != 0);
            chk("out_valid", out_valid, exp_v);
            chk("busy", busy, exp_v);
            chk("in_ready", in_ready, !exp_v && !reset);
            chk("done", done, exp_done);
            if (exp_v) begin
                head = exp_q[0];
                chk("out_data", out_data, head[BW-1 -: SL]);
                chk("out_addr", out_addr, head[AW:1]);
                chk("out_last", out_last, head[0]);
            end
            exp_done_nxt = 1'b0;
            if (exp_v && out_ready && !reset) begin
                head = exp_q.pop_front();
                got_q.push_back(head);
                exp_done_nxt = head[0];
            end
            in_fire_s = in_valid && !exp_v && !reset;
            if (in_fire_s) begin
                fire_done = done;
                for (int i = 0; i < BEATS; i++) begin
                    sh = in_line >> (i * SL);
                    ba = in_addr + AW'(i * BB);
                    exp_q.push_back({sh[SL-1:0], ba, (i == BEATS - 1)});
                end
            end
            if (reset) begin
                exp_q.delete();
                exp_done_nxt = 1'b0;
            end
            exp_done = exp_done_nxt;
        end
    end

    // Random backpressure while the random phase runs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [LW-1:0] line, input logic [AW-1:0] a);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_line  = line;
        in_addr  = a;
        for (int n = 0; n < 60; n++) begin
            cycle();
            if (in_fire_s) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) timeout("send_line");
    endtask

    task automatic wait_beats(input int n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) timeout("wait_beats");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) timeout("wait_idle");
        cycle();
        cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [LW-1:0] line;
        logic [AW-1:0] addr;
        logic [SL-1:0] d0;
        logic [AW-1:0] a0;
        logic [SL-1:0] d1;
        logic [AW-1:0] a1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{64'h1122334455667788, 16'h0040, 32'h55667788, 16'h0040, 32'h11223344, 16'h0044};
        vecs[1] = '{64'hAAAA0000BBBB1111, 16'h0100, 32'hBBBB1111, 16'h0100, 32'hAAAA0000, 16'h0104};
        vecs[2] = '{64'hDEADBEEFCAFEF00D, 16'hFFFC, 32'hCAFEF00D, 16'hFFFC, 32'hDEADBEEF, 16'h0000};
        vecs[3] = '{64'h0000000000000000, 16'h0002, 32'h00000000, 16'h0002, 32'h00000000, 16'h0006};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 16'hFFFE, 32'hFFFFFFFF, 16'hFFFE, 32'hFFFFFFFF, 16'h0002};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_line   = '0;
        in_addr   = '0;
        out_ready = 1'b0;
        repeat (3) cycle();

        // Reset state
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_addr", out_addr, 16'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        cycle();
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Table vectors: basic, address wrap, all-zero and all-one lines
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            send_line(vecs[v].line, vecs[v].addr);
            wait_beats(2);
            if (got_q.size() >= 2) begin
                chk("vec_d0", got_q[0][BW-1 -: SL], vecs[v].d0);
                chk("vec_a0", got_q[0][AW:1], vecs[v].a0);
                chk("vec_l0", got_q[0][0], 1'b0);
                chk("vec_d1", got_q[1][BW-1 -: SL], vecs[v].d1);
                chk("vec_a1", got_q[1][AW:1], vecs[v].a1);
                chk("vec_l1", got_q[1][0], 1'b1);
            end
            wait_idle();
        end

        // Backpressure: beat 0 held for three stalled cycles then accepted
        out_ready = 1'b0;
        got_q.delete();
        send_line(64'h1122334455667788, 16'h0040);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, 32'h55667788);
            chk("bp_addr", out_addr, 16'h0040);
            if (k == 3) out_ready = 1'b1;
            cycle();
        end
        wait_idle();
        chk("bp_beats", got_q.size(), 2);
        if (got_q.size() >= 2) chk("bp_order", got_q[1][BW-1 -: SL], 32'h11223344);

        // Busy ignore: second line offered during SEND, taken in the done cycle
        got_q.delete();
        send_line(64'h1122334455667788, 16'h0040);
        send_line(64'hAAAA0000BBBB1111, 16'h0200);
        chk("busy_accept_on_done", fire_done, 1'b1);
        wait_beats(4);
        if (got_q.size() >= 4) begin
            chk("busy_a_d1", got_q[1][BW-1 -: SL], 32'h11223344);
            chk("busy_b_d0", got_q[2][BW-1 -: SL], 32'hBBBB1111);
            chk("busy_b_a0", got_q[2][AW:1], 16'h0200);
        end
        wait_idle();

        // Reset mid-line after beat 0 accepted
        got_q.delete();
        send_line(64'h0123456789ABCDEF, 16'h0300);
        wait_beats(1);
        out_ready = 1'b0;
        reset     = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        repeat (3) cycle();
        chk("midrst_beats", got_q.size(), 1);
        got_q.delete();
        out_ready = 1'b1;
        send_line(64'hAAAA0000BBBB1111, 16'h0000);
        wait_beats(1);
        if (got_q.size() >= 1) chk("midrst_next_d0", got_q[0][BW-1 -: SL], 32'hBBBB1111);
        wait_idle();

        // Back-to-back: three lines with in_valid held
        got_q.delete();
        send_line(64'h0000000200000001, 16'h1000);
        send_line(64'h0000000400000003, 16'h2000);
        send_line(64'h0000000600000005, 16'h3000);
        wait_idle();
        chk("b2b_beats", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            chk("b2b_last", got_q[i][0], (i % 2) == 1);
            chk("b2b_data", got_q[i][BW-1 -: SL], 32'(i + 1));
        end

        // Random traffic against the model
        got_q.delete();
        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) cycle();
            send_line({$urandom, $urandom}, AW'($urandom));
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("rand_beats", got_q.size(), 120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
